// File: rtl/fanin_pkg.sv
// Shared definitions for the fan-in collector.
// Holds default sizing, the source-tag width rule and the default output beat type.
package fanin_pkg;

    localparam int unsigned N_CHILD_DEF = 5;
    localparam int unsigned DATA_W_DEF  = 8;

    // Width of the source tag; never narrower than one bit.
    function automatic int unsigned src_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned SRC_W_DEF = src_w(N_CHILD_DEF);

    // Output beat at the default configuration: {source index, payload}.
    typedef struct packed {
        logic [SRC_W_DEF-1:0]  src;
        logic [DATA_W_DEF-1:0] data;
    } beat_t;

endpackage

// File: rtl/fanin_collector_if.sv
// Bundle of the child-side and parent-side streams of the fan-in collector.
// slave : collector view (takes child streams and out_ready, drives the tagged output).
// master: environment view (drives child streams and out_ready, observes the output).
interface fanin_collector_if
    import fanin_pkg::*;
#(
    parameter int unsigned N_CHILD = N_CHILD_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
);
    localparam int unsigned SRC_W = src_w(N_CHILD);

    logic [N_CHILD-1:0]        in_valid;
    logic [N_CHILD-1:0]        in_ready;
    logic [N_CHILD*DATA_W-1:0] in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         out_data;
    logic [SRC_W-1:0]          out_src;
    logic [15:0]               xfer_count;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src, xfer_count
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src, xfer_count
    );

endinterface

// File: rtl/fanin_skid_fifo.sv
// Two-entry FIFO buffering one child stream.
// Ports: clk, rst_n (async, active-low), push/wdata write side,
//        pop read side, full/empty status, head = oldest entry.
module fanin_skid_fifo #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] slot0_q, slot0_d;  // head entry
    logic [DATA_W-1:0] slot1_q, slot1_d;  // second entry

    always_comb begin
        count_d = count_q + 2'(push) - 2'(pop);
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        if (pop) begin
            if (count_q == 2'd2) begin
                slot0_d = slot1_q;
            end else if (push) begin
                // Simultaneous push/pop at one entry: new word becomes head.
                slot0_d = wdata;
            end
        end else if (push) begin
            if (count_q == 2'd0) begin
                slot0_d = wdata;
            end else begin
                slot1_d = wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            count_q <= count_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign head  = slot0_q;

endmodule

// File: rtl/fanin_collector.sv
// Merges N_CHILD valid/ready child streams into one tagged output stream.
// Each child feeds a 2-entry FIFO; a round-robin arbiter pops one FIFO per load
// into a registered output stage carrying {src, data}. xfer_count wraps at 16 bits.
// Ports: clk, rst_n (async, active-low), bus (slave view of fanin_collector_if).
module fanin_collector
    import fanin_pkg::*;
#(
    parameter int unsigned N_CHILD = N_CHILD_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
) (
    input logic               clk,
    input logic               rst_n,
    fanin_collector_if.slave  bus
);

    localparam int unsigned SRC_W = src_w(N_CHILD);

    typedef struct packed {
        logic [SRC_W-1:0]  src;
        logic [DATA_W-1:0] data;
    } out_beat_t;

    logic [N_CHILD-1:0] fifo_full;
    logic [N_CHILD-1:0] fifo_empty;
    logic [N_CHILD-1:0] fifo_push;
    logic [N_CHILD-1:0] fifo_pop;
    logic [DATA_W-1:0]  fifo_head [N_CHILD];

    logic               grant_valid;
    logic [SRC_W-1:0]   grant_idx;
    int unsigned        cand;
    logic               load;

    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               out_valid_q, out_valid_d;
    out_beat_t          out_beat_q, out_beat_d;
    logic [15:0]        xfer_count_q, xfer_count_d;

    for (genvar i = 0; i < N_CHILD; i++) begin : g_child
        assign fifo_push[i] = bus.in_valid[i] && !fifo_full[i];
        assign fifo_pop[i]  = load && grant_valid && (grant_idx == SRC_W'(i));

        fanin_skid_fifo #(
            .DATA_W (DATA_W)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (fifo_push[i]),
            .wdata (bus.in_data[i*DATA_W +: DATA_W]),
            .pop   (fifo_pop[i]),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i]),
            .head  (fifo_head[i])
        );
    end

    // Ready depends only on registered FIFO occupancy.
    assign bus.in_ready = ~fifo_full;

    assign load = !out_valid_q || bus.out_ready;

    // First non-empty FIFO in rotating order starting at rr_ptr_q.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned k = 0; k < N_CHILD; k++) begin
            cand = (32'(rr_ptr_q) + k) % N_CHILD;
            if (!grant_valid && !fifo_empty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = SRC_W'(cand);
            end
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_beat_d   = out_beat_q;
        rr_ptr_d     = rr_ptr_q;
        xfer_count_d = xfer_count_q + 16'(out_valid_q && bus.out_ready);
        if (load) begin
            if (grant_valid) begin
                out_valid_d     = 1'b1;
                out_beat_d.src  = grant_idx;
                out_beat_d.data = fifo_head[grant_idx];
                rr_ptr_d        = (grant_idx == SRC_W'(N_CHILD - 1)) ? '0 : grant_idx + 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            out_valid_q  <= 1'b0;
            out_beat_q   <= '0;
            xfer_count_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            out_valid_q  <= out_valid_d;
            out_beat_q   <= out_beat_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_beat_q.data;
    assign bus.out_src    = out_beat_q.src;
    assign bus.xfer_count = xfer_count_q;

endmodule

// File: tb/tb_fanin_collector.sv
// Directed self-checking bench for fanin_collector (5 children, 8-bit data).
// Child payload = base[i] + number of beats already accepted from child i.
module tb_fanin_collector;
    import fanin_pkg::*;

    logic clk;
    logic rst_n;

    fanin_collector_if #(.N_CHILD(5), .DATA_W(8)) bus ();

    fanin_collector #(
        .N_CHILD (5),
        .DATA_W  (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec;
    int         n_err;
    int         seq   [5];
    int         limit [5];
    logic [7:0] base  [5];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat_obs();
        return 32'({bus.out_valid, bus.out_src, bus.out_data});
    endfunction

    function automatic logic [31:0] beat_exp(input int src, input int d);
        beat_t b;
        b.src  = 3'(src);
        b.data = 8'(d);
        return 32'({1'b1, b});
    endfunction

    task automatic drive_data();
        for (int i = 0; i < 5; i++) begin
            bus.in_data[i*8 +: 8] = base[i] + 8'(seq[i]);
        end
    endtask

    // One clock: inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        logic [4:0] acc;
        acc = bus.in_valid & bus.in_ready;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (acc[i]) seq[i]++;
            if (limit[i] != 0 && seq[i] >= limit[i]) bus.in_valid[i] = 1'b0;
        end
        drive_data();
    endtask

    task automatic setup(input logic [4:0] valid, input logic rdy);
        for (int i = 0; i < 5; i++) begin
            seq[i]   = 0;
            limit[i] = 0;
            base[i]  = 8'(i * 32);
        end
        bus.in_valid  = valid;
        bus.out_ready = rdy;
        drive_data();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        bus.in_data = '0;

        // Reset with all children asserting valid.
        @(negedge clk);
        setup(5'b11111, 1'b1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'h1f);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out_data", 32'(bus.out_data), 32'h0);
        check("rst_out_src", 32'(bus.out_src), 32'h0);
        check("rst_xfer_count", 32'(bus.xfer_count), 32'h0);
        rst_n = 1'b1;

        // Fairness: first beat after one-cycle latency comes from child 0.
        tick();
        check("latency_idle", 32'(bus.out_valid), 32'h0);
        tick();
        for (int n = 0; n < 20; n++) begin
            check($sformatf("fair_%0d", n), beat_obs(), beat_exp(n % 5, (n % 5) * 32 + n / 5));
            tick();
        end
        check("fair_xfer_count", 32'(bus.xfer_count), 32'd20);

        // Single child: child 3 sends 8'h10..8'h17 back-to-back.
        setup(5'b00000, 1'b1);
        do_reset();
        base[3]  = 8'h10;
        limit[3] = 8;
        bus.in_valid = 5'b01000;
        drive_data();
        tick();
        check("single_latency", 32'(bus.out_valid), 32'h0);
        for (int n = 0; n < 8; n++) begin
            tick();
            check($sformatf("single_%0d", n), beat_obs(), beat_exp(3, 8'h10 + n));
        end
        tick();
        check("single_drained", 32'(bus.out_valid), 32'h0);
        check("single_xfer_count", 32'(bus.xfer_count), 32'd8);

        // Backpressure: out_ready low 10 cycles, 11 beats held, drained in order.
        setup(5'b11111, 1'b0);
        do_reset();
        repeat (10) tick();
        check("bp_in_ready", 32'(bus.in_ready), 32'h0);
        check("bp_held", beat_obs(), beat_exp(0, 0));
        bus.in_valid  = 5'b00000;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 11; n++) begin
            if (n == 1) check("bp_ready_after_pop", 32'(bus.in_ready), 32'h02);
            check($sformatf("bp_drain_%0d", n), beat_obs(), beat_exp(n % 5, (n % 5) * 32 + n / 5));
            tick();
        end
        check("bp_empty", 32'(bus.out_valid), 32'h0);
        check("bp_xfer_count", 32'(bus.xfer_count), 32'd11);
        check("bp_in_ready_back", 32'(bus.in_ready), 32'h1f);

        // Wrap: 65536 transfers read 0, the next one reads 1.
        setup(5'b00001, 1'b1);
        do_reset();
        repeat (65538) tick();
        check("wrap_zero", 32'(bus.xfer_count), 32'h0);
        tick();
        check("wrap_one", 32'(bus.xfer_count), 32'h1);
        check("wrap_streaming", 32'(bus.out_valid), 32'h1);

        // Mid-operation reset with full FIFOs and a held output.
        setup(5'b11111, 1'b0);
        do_reset();
        repeat (10) tick();
        check("midrst_pre_valid", 32'(bus.out_valid), 32'h1);
        check("midrst_pre_ready", 32'(bus.in_ready), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_async_valid", 32'(bus.out_valid), 32'h0);
        check("midrst_async_ready", 32'(bus.in_ready), 32'h1f);
        check("midrst_async_data", 32'(bus.out_data), 32'h0);
        @(negedge clk);
        setup(5'b00000, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            check($sformatf("midrst_no_stale_%0d", n), 32'(bus.out_valid), 32'h0);
        end
        base[2]  = 8'hA5;
        limit[2] = 1;
        bus.in_valid = 5'b00100;
        drive_data();
        tick();
        tick();
        check("midrst_fresh", beat_obs(), beat_exp(2, 8'hA5));
        tick();
        check("midrst_fresh_done", 32'(bus.out_valid), 32'h0);
        check("midrst_xfer_count", 32'(bus.xfer_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
